// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared types and constants for the router packet transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;
    localparam int DATA_W = 8;

    // Header layout: length in the upper bits, destination in the lower bits.
    localparam int c_hdr_addr_lsb = 0;
    localparam int c_hdr_len_lsb  = ADDR_W;

    localparam logic [ADDR_W-1:0] c_addr_illegal = ADDR_W'(3);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        PAYLOAD = 3'd2,
        PARITY  = 3'd3,
        CHECK   = 3'd4
    } tx_state_e;

    function automatic logic [DATA_W-1:0] make_header(
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] addr
    );
        logic [DATA_W-1:0] hdr;
        hdr = '0;
        hdr[c_hdr_len_lsb +: LEN_W]   = len;
        hdr[c_hdr_addr_lsb +: ADDR_W] = addr;
        return hdr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_tx_buf.sv
`default_nettype none
// ============================================================================
// Module      : router_tx_buf
// Description : Payload store, one synchronous write port, one async read port.
// Revision    : 1.0 - initial release
// ============================================================================
module router_tx_buf
    import router_pkg::*;
#(
    parameter int DEPTH = 63,
    parameter int AW    = 6
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_rd_in_range;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Look-ahead reads can run one past the last entry; return zero there.
    assign w_rd_in_range = (32'(i_raddr) < 32'(DEPTH));
    assign o_rdata       = w_rd_in_range ? r_mem[i_raddr] : '0;

endmodule
`default_nettype wire

// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module      : router_pkt_tx
// Description : Buffers a payload and sends header/payload/parity to a router.
// Revision    : 1.0 - initial release
// ============================================================================
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int MAX_LEN  = 63,
    parameter int CHK_WAIT = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              ld_en,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic              busy,
    input  logic              err,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_active,
    output logic [6:0]        ld_count,
    output logic              done,
    output logic              reject,
    output logic              pkt_err
);

    localparam int          c_buf_aw   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [6:0]  c_max_len  = 7'(MAX_LEN);
    localparam logic [7:0]  c_chk_last = (CHK_WAIT > 1) ? 8'(CHK_WAIT - 1) : 8'd0;

    tx_state_e          r_state;
    logic [LEN_W-1:0]   r_idx;
    logic [6:0]         r_ld_count;
    logic [ADDR_W-1:0]  r_dest;
    logic [DATA_W-1:0]  r_parity;
    logic [DATA_W-1:0]  r_tx_data;
    logic               r_pkt_valid;
    logic               r_done;
    logic               r_reject;
    logic               r_pkt_err;
    logic [7:0]         r_wait_cnt;

    logic               w_we;
    logic               w_last;
    logic [LEN_W-1:0]   w_rd_idx;
    logic [DATA_W-1:0]  w_rd_data;

    // A start in the same cycle as ld_en takes priority and drops the load.
    assign w_we     = (r_state == IDLE) && ld_en && !start && (r_ld_count < c_max_len);
    assign w_last   = ({1'b0, r_idx} == (r_ld_count - 7'd1));
    // Outputs are registered, so the buffer is read one byte ahead.
    assign w_rd_idx = (r_state == HEADER) ? '0 : r_idx + 1'b1;

    router_tx_buf #(
        .DEPTH (MAX_LEN),
        .AW    (c_buf_aw)
    ) u_buf (
        .clk     (clock),
        .i_we    (w_we),
        .i_waddr (r_ld_count[c_buf_aw-1:0]),
        .i_wdata (ld_data),
        .i_raddr (w_rd_idx[c_buf_aw-1:0]),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_ld_count  <= '0;
            r_dest      <= '0;
            r_parity    <= '0;
            r_tx_data   <= '0;
            r_pkt_valid <= 1'b0;
            r_done      <= 1'b0;
            r_reject    <= 1'b0;
            r_pkt_err   <= 1'b0;
            r_wait_cnt  <= '0;
        end else begin
            r_done   <= 1'b0;
            r_reject <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if ((r_ld_count == 7'd0) || (dest_addr == c_addr_illegal)) begin
                            r_reject <= 1'b1;
                        end else begin
                            r_state     <= HEADER;
                            r_dest      <= dest_addr;
                            r_pkt_err   <= 1'b0;
                            r_parity    <= '0;
                            r_idx       <= '0;
                            r_pkt_valid <= 1'b1;
                            r_tx_data   <= make_header(r_ld_count[LEN_W-1:0], dest_addr);
                        end
                    end else if (w_we) begin
                        r_ld_count <= r_ld_count + 7'd1;
                    end
                end
                HEADER: begin
                    if (!busy) begin
                        r_parity  <= make_header(r_ld_count[LEN_W-1:0], r_dest);
                        r_state   <= PAYLOAD;
                        r_idx     <= '0;
                        r_tx_data <= w_rd_data;
                    end
                end
                PAYLOAD: begin
                    if (!busy) begin
                        r_parity <= r_parity ^ r_tx_data;
                        if (w_last) begin
                            r_state     <= PARITY;
                            r_pkt_valid <= 1'b0;
                            r_tx_data   <= r_parity ^ r_tx_data;
                        end else begin
                            r_idx     <= r_idx + 1'b1;
                            r_tx_data <= w_rd_data;
                        end
                    end
                end
                PARITY: begin
                    if (!busy) begin
                        r_state    <= CHECK;
                        r_tx_data  <= '0;
                        r_wait_cnt <= '0;
                    end
                end
                CHECK: begin
                    if (r_wait_cnt == c_chk_last) begin
                        r_pkt_err  <= err;
                        r_done     <= 1'b1;
                        r_ld_count <= '0;
                        r_state    <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_pkt_valid <= 1'b0;
                    r_tx_data   <= '0;
                end
            endcase
        end
    end

    assign pkt_valid = r_pkt_valid;
    assign tx_data   = r_tx_data;
    assign tx_active = (r_state != IDLE);
    assign ld_count  = r_ld_count;
    assign done      = r_done;
    assign reject    = r_reject;
    assign pkt_err   = r_pkt_err;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_pkt_tx
// Description : Self-checking bench for router_pkt_tx with a packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_pkt_tx;

    localparam int MAX_LEN  = 63;
    localparam int CHK_WAIT = 2;

    logic       clock = 1'b0;
    logic       resetn;
    logic       ld_en;
    logic [7:0] ld_data;
    logic       start;
    logic [1:0] dest_addr;
    logic       busy;
    logic       err;
    logic       pkt_valid;
    logic [7:0] tx_data;
    logic       tx_active;
    logic [6:0] ld_count;
    logic       done;
    logic       reject;
    logic       pkt_err;

    int n_tests = 0;
    int n_fail  = 0;

    router_pkt_tx #(
        .MAX_LEN  (MAX_LEN),
        .CHK_WAIT (CHK_WAIT)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .ld_en     (ld_en),
        .ld_data   (ld_data),
        .start     (start),
        .dest_addr (dest_addr),
        .busy      (busy),
        .err       (err),
        .pkt_valid (pkt_valid),
        .tx_data   (tx_data),
        .tx_active (tx_active),
        .ld_count  (ld_count),
        .done      (done),
        .reject    (reject),
        .pkt_err   (pkt_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Packet-level model: the bytes still to go out, the loaded payload, and
    // the number of check cycles left before completion.
    bit         m_active   = 1'b0;
    bit         m_done     = 1'b0;
    bit         m_reject   = 1'b0;
    bit         m_pkt_err  = 1'b0;
    int         m_chk_left = 0;
    logic [6:0] m_count    = 7'd0;
    logic [7:0] m_q[$];
    logic [7:0] m_buf[$];
    logic [7:0] m_hdr;
    logic [7:0] m_par;

    always @(negedge clock) begin
        if (!resetn) begin
            check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
            check("rst_tx_data",   32'(tx_data),   32'd0);
            check("rst_tx_active", 32'(tx_active), 32'd0);
            check("rst_ld_count",  32'(ld_count),  32'd0);
            check("rst_done",      32'(done),      32'd0);
            check("rst_reject",    32'(reject),    32'd0);
            check("rst_pkt_err",   32'(pkt_err),   32'd0);
            m_active = 1'b0; m_done = 1'b0; m_reject = 1'b0; m_pkt_err = 1'b0;
            m_chk_left = 0; m_count = 7'd0;
            m_q.delete(); m_buf.delete();
        end else begin
            check("cmp_tx_active", 32'(tx_active), 32'(m_active));
            check("cmp_ld_count",  32'(ld_count),  32'(m_count));
            check("cmp_done",      32'(done),      32'(m_done));
            check("cmp_reject",    32'(reject),    32'(m_reject));
            check("cmp_pkt_err",   32'(pkt_err),   32'(m_pkt_err));
            if (m_q.size() > 0) begin
                check("cmp_pkt_valid", 32'(pkt_valid), 32'(m_q.size() > 1));
                check("cmp_tx_data",   32'(tx_data),   32'(m_q[0]));
            end else begin
                check("cmp_pkt_valid", 32'(pkt_valid), 32'd0);
                check("cmp_tx_data",   32'(tx_data),   32'd0);
            end
            m_done   = 1'b0;
            m_reject = 1'b0;
            if (!m_active) begin
                if (start) begin
                    if (m_count == 7'd0 || dest_addr == 2'd3) begin
                        m_reject = 1'b1;
                    end else begin
                        m_hdr = {m_count[5:0], dest_addr};
                        m_par = m_hdr;
                        m_q.delete();
                        m_q.push_back(m_hdr);
                        foreach (m_buf[i]) begin
                            m_q.push_back(m_buf[i]);
                            m_par = m_par ^ m_buf[i];
                        end
                        m_q.push_back(m_par);
                        m_pkt_err = 1'b0;
                        m_active  = 1'b1;
                    end
                end else if (ld_en && m_count < 7'(MAX_LEN)) begin
                    m_buf.push_back(ld_data);
                    m_count = m_count + 7'd1;
                end
            end else if (m_q.size() > 0) begin
                if (!busy) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_chk_left = CHK_WAIT;
                end
            end else begin
                m_chk_left = m_chk_left - 1;
                if (m_chk_left <= 0) begin
                    m_done    = 1'b1;
                    m_pkt_err = err;
                    m_count   = 7'd0;
                    m_buf.delete();
                    m_active  = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [7:0] b);
        ld_en   = 1'b1;
        ld_data = b;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic send_start(input logic [1:0] d);
        start     = 1'b1;
        dest_addr = d;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    logic [7:0] lit_b  [5];
    logic       lit_pv [5];

    initial begin
        lit_b  = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        lit_pv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        resetn = 1'b0; ld_en = 1'b0; ld_data = 8'h00; start = 1'b0;
        dest_addr = 2'd0; busy = 1'b0; err = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_tx_active", 32'(tx_active), 32'd0);
        check("reset_ld_count",  32'(ld_count),  32'd0);
        resetn = 1'b1;
        tick();

        // Basic three-byte packet to port 1
        load(8'h11); load(8'h22); load(8'h33);
        check("load3_count", 32'(ld_count), 32'd3);
        send_start(2'd1);
        for (int i = 0; i < 5; i++) begin
            check("basic_tx_data",   32'(tx_data),   32'(lit_b[i]));
            check("basic_pkt_valid", 32'(pkt_valid), 32'(lit_pv[i]));
            tick();
        end
        for (int k = 1; k <= CHK_WAIT + 1; k++) begin
            check("basic_done_time", 32'(done), 32'(k == CHK_WAIT + 1));
            if (k <= CHK_WAIT) tick();
        end
        tick();

        // Same packet with busy held over the second payload byte
        load(8'h11); load(8'h22); load(8'h33);
        send_start(2'd1);
        check("busy_hdr", 32'(tx_data), 32'h0D);
        tick();
        check("busy_p0", 32'(tx_data), 32'h11);
        tick();
        check("busy_p1", 32'(tx_data), 32'h22);
        busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("busy_hold_data", 32'(tx_data),   32'h22);
            check("busy_hold_pv",   32'(pkt_valid), 32'd1);
        end
        busy = 1'b0;
        tick();
        check("busy_p2", 32'(tx_data), 32'h33);
        tick();
        check("busy_parity",    32'(tx_data),   32'h0D);
        check("busy_parity_pv", 32'(pkt_valid), 32'd0);
        wait_done(20);

        // Illegal starts: empty buffer, then address 3 with a colliding load
        tick();
        send_start(2'd0);
        check("rej_empty",        32'(reject),    32'd1);
        check("rej_empty_active", 32'(tx_active), 32'd0);
        tick();
        check("rej_empty_pulse",  32'(reject),    32'd0);
        load(8'hA5); load(8'h5A);
        start = 1'b1; dest_addr = 2'd3; ld_en = 1'b1; ld_data = 8'hFF;
        tick();
        start = 1'b0; ld_en = 1'b0;
        check("rej_addr3",       32'(reject),   32'd1);
        check("rej_addr3_count", 32'(ld_count), 32'd2);
        tick();

        // Parity error result held through idle, cleared by next legal start
        err = 1'b1;
        send_start(2'd2);
        check("err_hdr", 32'(tx_data), 32'h0A);
        wait_done(20);
        check("err_latched", 32'(pkt_err), 32'd1);
        repeat (3) tick();
        check("err_held", 32'(pkt_err), 32'd1);
        err = 1'b0;
        load(8'h77);
        send_start(2'd0);
        check("err_cleared", 32'(pkt_err), 32'd0);
        check("one_byte_hdr", 32'(tx_data), 32'h04);
        wait_done(20);
        tick();

        // Full buffer: 64th load is dropped
        for (int i = 0; i < 64; i++) load(8'(i * 7 + 3));
        check("full_count", 32'(ld_count), 32'd63);
        send_start(2'd2);
        check("full_hdr", 32'(tx_data), 32'hFE);
        wait_done(100);
        tick();

        // Reset in the middle of the payload
        load(8'h01); load(8'h02); load(8'h03); load(8'h04);
        send_start(2'd1);
        tick(); tick();
        check("mid_payload", 32'(tx_data), 32'h02);
        resetn = 1'b0;
        #1;
        check("async_pkt_valid", 32'(pkt_valid), 32'd0);
        check("async_ld_count",  32'(ld_count),  32'd0);
        check("async_tx_active", 32'(tx_active), 32'd0);
        tick(); tick();
        check("rst_no_done", 32'(done), 32'd0);
        resetn = 1'b1;
        tick();
        load(8'h5C); load(8'hC5);
        send_start(2'd2);
        check("post_rst_hdr", 32'(tx_data), 32'h0A);
        wait_done(20);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
